// File: rtl/mux_2level_cfg_chain_if.sv
// mux_2level_cfg_chain_if
//   Groups the configuration-chain handshake and the routed datapath of one
//   mux_2level_cfg_chain instance.
//   master : the configuration controller / routing fabric driving the mux
//   slave  : the mux itself
// Signals:
//   cfg_start  - one-cycle request to begin loading a new config
//   ccff_valid - ccff_head carries a valid bit this cycle
//   ccff_head  - serial config input
//   ccff_tail  - serial config output (MSB of the shadow chain)
//   in         - routed inputs, N_IN wide
//   out        - selected input
//   cfg_busy   - loader is shifting or checking
//   cfg_ok     - one-cycle pulse, commit accepted
//   cfg_err    - one-cycle pulse, commit rejected
//   sel_valid  - active config holds a legal selection
interface mux_2level_cfg_chain_if #(
    parameter int N_IN = 16
);
    logic            cfg_start;
    logic            ccff_valid;
    logic            ccff_head;
    logic            ccff_tail;
    logic [N_IN-1:0] in;
    logic            out;
    logic            cfg_busy;
    logic            cfg_ok;
    logic            cfg_err;
    logic            sel_valid;

    modport master (
        output cfg_start, ccff_valid, ccff_head, in,
        input  ccff_tail, out, cfg_busy, cfg_ok, cfg_err, sel_valid
    );

    modport slave (
        input  cfg_start, ccff_valid, ccff_head, in,
        output ccff_tail, out, cfg_busy, cfg_ok, cfg_err, sel_valid
    );
endinterface

// File: rtl/mux_2level_cfg_chain.sv
// mux_2level_cfg_chain
//   N_IN-input two-level routing mux with its own serial configuration chain.
//   A shadow register is loaded serially (ccff_head -> ccff_tail), checked
//   for a legal one-hot/one-hot selection in a single CHECK cycle and then
//   committed atomically to the active select bits. The routing path is
//   purely combinational from the committed configuration.
// Ports:
//   prog_clk     - configuration clock
//   prog_reset_n - asynchronous active-low reset
//   bus          - mux_2level_cfg_chain_if.slave (chain handshake + datapath);
//                  the interface N_IN must match this module's N_IN
// Parameters:
//   N_IN    - number of routed inputs (2..64)
//   L1_SIZE - inputs per first-level group (2..8)
// Build option:
//   MUX_CFG_PARITY_EN - appends an even-parity bit (shadow bit 0, shifted in
//                       last) and rejects commits whose parity is odd.
module mux_2level_cfg_chain #(
    parameter int N_IN    = 16,
    parameter int L1_SIZE = 4
) (
    input logic                   prog_clk,
    input logic                   prog_reset_n,
    mux_2level_cfg_chain_if.slave bus
);

    localparam int N_GRP    = (N_IN + L1_SIZE - 1) / L1_SIZE;
    localparam int MEM_BITS = L1_SIZE + N_GRP;
    // Number of usable inputs in the last group (equals L1_SIZE when full).
    localparam int LAST_W   = N_IN - (N_GRP - 1) * L1_SIZE;

`ifdef MUX_CFG_PARITY_EN
    localparam int CHAIN_LEN = MEM_BITS + 1;
    localparam int FLD_LSB   = 1;
`else
    localparam int CHAIN_LEN = MEM_BITS;
    localparam int FLD_LSB   = 0;
`endif

    localparam int                CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0]   shadow_q;
    logic [MEM_BITS-1:0]    active_q;
    logic                   sel_valid_q;

    logic                   shift_en;
    logic                   commit;
    logic                   ok_pulse;
    logic                   err_pulse;

    // ------------------------------------------------------------------
    // Shadow legality check
    // ------------------------------------------------------------------
    logic [L1_SIZE-1:0]     sh_l1;
    logic [N_GRP-1:0]       sh_l2;
    logic                   range_ok;
    logic                   parity_ok;
    logic                   legal;

    assign sh_l1 = shadow_q[FLD_LSB +: L1_SIZE];
    assign sh_l2 = shadow_q[FLD_LSB + L1_SIZE +: N_GRP];

    // Only the last group can be partial; with both fields one-hot, an
    // out-of-range index means last group selected together with one of its
    // missing input positions.
    always_comb begin
        range_ok = 1'b1;
        for (int unsigned i = LAST_W; i < L1_SIZE; i++) begin
            if (sh_l2[N_GRP-1] && sh_l1[i]) begin
                range_ok = 1'b0;
            end
        end
    end

`ifdef MUX_CFG_PARITY_EN
    assign parity_ok = ~(^shadow_q);
`else
    assign parity_ok = 1'b1;
`endif

    assign legal = $onehot(sh_l1) && $onehot(sh_l2) && range_ok && parity_ok;

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        commit    = 1'b0;
        ok_pulse  = 1'b0;
        err_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (bus.ccff_valid) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (legal) begin
                    commit   = 1'b1;
                    ok_pulse = 1'b1;
                end else begin
                    err_pulse = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (shift_en) begin
                shadow_q <= {shadow_q[CHAIN_LEN-2:0], bus.ccff_head};
            end
            if (commit) begin
                active_q    <= shadow_q[FLD_LSB +: MEM_BITS];
                sel_valid_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-level routing datapath
    // ------------------------------------------------------------------
    logic [N_GRP*L1_SIZE-1:0] in_pad;
    logic [N_GRP-1:0]         grp_out;
    logic [L1_SIZE-1:0]       act_l1;
    logic [N_GRP-1:0]         act_l2;

    assign act_l1 = active_q[L1_SIZE-1:0];
    assign act_l2 = active_q[MEM_BITS-1:L1_SIZE];

    // Missing inputs of a partial last group read as 0; they can never be
    // selected by a committed config anyway.
    always_comb begin
        in_pad           = '0;
        in_pad[N_IN-1:0] = bus.in;
    end

    // Active config is always one-hot per level, so AND-OR acts as a mux.
    always_comb begin
        grp_out = '0;
        for (int unsigned g = 0; g < N_GRP; g++) begin
            grp_out[g] = |(in_pad[g*L1_SIZE +: L1_SIZE] & act_l1);
        end
    end

    assign bus.out       = sel_valid_q & (|(grp_out & act_l2));
    assign bus.ccff_tail = shadow_q[CHAIN_LEN-1];
    assign bus.cfg_busy  = (state_q != S_IDLE);
    assign bus.cfg_ok    = ok_pulse;
    assign bus.cfg_err   = err_pulse;
    assign bus.sel_valid = sel_valid_q;

endmodule

// File: tb/tb_mux_2level_cfg_chain.sv
// tb_mux_2level_cfg_chain
//   Drives two instances (N_IN=16 and N_IN=14, L1_SIZE=4, identical chain
//   streams) and checks them every cycle against a behavioural model, plus
//   hand-computed literal expectations for the directed scenarios.
module tb_mux_2level_cfg_chain;

    localparam int L1  = 4;
    localparam int NA  = 16;
    localparam int NB  = 14;
    localparam int MEM = 8;   // L1 + ceil(N/L1) = 4 + 4 for both instances
`ifdef MUX_CFG_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int CL  = MEM + PB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        valid = 1'b0;
    logic        head = 1'b0;
    logic [15:0] in_v = '0;
    bit          rand_in = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_run = 0;
    int last_busy = 0;

    always #5 clk = ~clk;

    mux_2level_cfg_chain_if #(.N_IN(NA)) bus_a();
    mux_2level_cfg_chain_if #(.N_IN(NB)) bus_b();

    assign bus_a.cfg_start  = cfg_start;
    assign bus_a.ccff_valid = valid;
    assign bus_a.ccff_head  = head;
    assign bus_a.in         = in_v;
    assign bus_b.cfg_start  = cfg_start;
    assign bus_b.ccff_valid = valid;
    assign bus_b.ccff_head  = head;
    assign bus_b.in         = in_v[NB-1:0];

    mux_2level_cfg_chain #(.N_IN(NA), .L1_SIZE(L1)) dut_a (
        .prog_clk    (clk),
        .prog_reset_n(rst_n),
        .bus         (bus_a)
    );

    mux_2level_cfg_chain #(.N_IN(NB), .L1_SIZE(L1)) dut_b (
        .prog_clk    (clk),
        .prog_reset_n(rst_n),
        .bus         (bus_b)
    );

    // ---------------- behavioural model ----------------
    logic [15:0] m_shadow = '0;
    int          m_cnt = 0;
    bit          m_loading = 1'b0;
    bit          m_check = 1'b0;
    bit          m_selv[2];
    int          m_idx[2];

    function automatic int nin_of(input int d);
        return (d == 0) ? NA : NB;
    endfunction

    // Decode the shadow word from the field rules; returns legality.
    function automatic bit decode(input logic [15:0] sh, input int n_in, output int idx);
        int l1cnt;
        int l2cnt;
        int ipos;
        int gpos;
        bit ok;
        l1cnt = 0; l2cnt = 0; ipos = 0; gpos = 0;
        for (int b = 0; b < L1; b++)
            if (sh[PB + b]) begin l1cnt++; ipos = b; end
        for (int b = 0; b < MEM - L1; b++)
            if (sh[PB + L1 + b]) begin l2cnt++; gpos = b; end
        idx = gpos * L1 + ipos;
        ok = (l1cnt == 1) && (l2cnt == 1) && (idx < n_in);
        if (PB == 1 && (^sh) != 1'b0) ok = 1'b0;
        return ok;
    endfunction

    always @(posedge clk) begin
        int idx;
        cyc++;
        if (!rst_n) begin
            m_shadow  = '0;
            m_cnt     = 0;
            m_loading = 1'b0;
            m_check   = 1'b0;
            for (int d = 0; d < 2; d++) begin m_selv[d] = 1'b0; m_idx[d] = 0; end
        end else if (m_check) begin
            for (int d = 0; d < 2; d++)
                if (decode(m_shadow, nin_of(d), idx)) begin
                    m_selv[d] = 1'b1;
                    m_idx[d]  = idx;
                end
            m_check = 1'b0;
        end else if (m_loading) begin
            if (valid) begin
                m_shadow = 16'(((int'(m_shadow) << 1) | int'(head)) & ((1 << CL) - 1));
                m_cnt++;
                if (m_cnt == CL) begin
                    m_loading = 1'b0;
                    m_check   = 1'b1;
                end
            end
        end else if (cfg_start) begin
            m_loading = 1'b1;
            m_cnt     = 0;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic busy, input logic ok, input logic err,
                           input logic tail, input logic selv, input logic out);
        int  idx;
        bit  leg;
        bit  e_selv;
        leg    = decode(m_shadow, nin_of(d), idx);
        e_selv = rst_n && m_selv[d];
        chk((d == 0) ? "a_busy" : "b_busy", busy, rst_n && (m_loading || m_check));
        chk((d == 0) ? "a_ok"   : "b_ok",   ok,   rst_n && m_check && leg);
        chk((d == 0) ? "a_err"  : "b_err",  err,  rst_n && m_check && !leg);
        chk((d == 0) ? "a_tail" : "b_tail", tail, rst_n && m_shadow[CL-1]);
        chk((d == 0) ? "a_selv" : "b_selv", selv, e_selv);
        chk((d == 0) ? "a_out"  : "b_out",  out,  e_selv && in_v[m_idx[d]]);
    endtask

    always @(negedge clk) begin
        cmp_dut(0, bus_a.cfg_busy, bus_a.cfg_ok, bus_a.cfg_err, bus_a.ccff_tail,
                bus_a.sel_valid, bus_a.out);
        cmp_dut(1, bus_b.cfg_busy, bus_b.cfg_ok, bus_b.cfg_err, bus_b.ccff_tail,
                bus_b.sel_valid, bus_b.out);
        if (bus_a.cfg_busy) busy_run++;
        else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_in) in_v = 16'($urandom);
    endtask

    function automatic logic [15:0] mk(input logic [7:0] w);
        return (PB == 1) ? {7'b0, w, ^w} : {8'b0, w};
    endfunction

    // Issue cfg_start then shift CL bits MSB first. Returns positioned in the
    // cycle right after the last shift edge (the CHECK cycle).
    task automatic load(input logic [15:0] w, input int stall_at, input int stall_len,
                        input bit noise, input int abort_at);
        cfg_start = 1'b1;
        start_cyc = cyc;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < CL; k++) begin
            if (k == stall_at)
                repeat (stall_len) begin valid = 1'b0; tick(); end
            if (noise && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin
                    valid = 1'b0; head = 1'($urandom); cfg_start = 1'($urandom); tick();
                end
            if (k == abort_at) begin
                valid = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1;
            end
            valid = 1'b1;
            head  = w[CL-1-k];
            if (noise) cfg_start = 1'($urandom);
            tick();
        end
        valid = 1'b0;
        head = 1'b0;
        cfg_start = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  w8;
        int          g;
        int          i;

        // Reset
        rst_n = 1'b0;
        in_v  = 16'hFFFF;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out", bus_a.out, 1'b0);
        chk("rst_selv", bus_a.sel_valid, 1'b0);
        chk("rst_busy", bus_a.cfg_busy, 1'b0);
        chk("rst_tail", bus_a.ccff_tail, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rel_out", bus_a.out, 1'b0);
        chk("rel_selv", bus_a.sel_valid, 1'b0);

        // Legal load: group 1, input 2 (index 6)
        in_v = 16'h0040;
        tick();
        load(mk(8'h24), -1, 0, 1'b0, -1);
        @(negedge clk);
        chk("legal_ok", bus_a.cfg_ok, 1'b1);
        chk_int("legal_ok_cycle", cyc - start_cyc, (PB == 1) ? 10 : 9);
        tick();
        @(negedge clk);
        chk("legal_selv", bus_a.sel_valid, 1'b1);
        chk("legal_out1", bus_a.out, 1'b1);
        chk("legal_busy", bus_a.cfg_busy, 1'b0);
        tick();
        in_v = 16'hFFBF;
        @(negedge clk);
        chk("legal_out0", bus_a.out, 1'b0);
        chk_int("busy_len", last_busy, CL + 1);

        // Stalled load: 3 idle cycles mid-stream
        in_v = 16'h0040;
        tick();
        load(mk(8'h24), 4, 3, 1'b0, -1);
        @(negedge clk);
        chk("stall_ok", bus_a.cfg_ok, 1'b1);
        tick();
        tick();
        @(negedge clk);
        chk_int("stall_busy_len", last_busy, CL + 1 + 3);
        chk("stall_out", bus_a.out, 1'b1);

        // Illegal one-hot: previous selection kept
        load(mk(8'h36), -1, 0, 1'b0, -1);
        @(negedge clk);
        chk("ill_err", bus_a.cfg_err, 1'b1);
        chk("ill_ok", bus_a.cfg_ok, 1'b0);
        tick();
        @(negedge clk);
        chk("ill_selv", bus_a.sel_valid, 1'b1);
        chk("ill_out", bus_a.out, 1'b1);

        // Group 3, input 3: legal on 16 inputs, out of range on 14
        tick();
        load(mk(8'h88), -1, 0, 1'b0, -1);
        @(negedge clk);
        chk("oor_a_ok", bus_a.cfg_ok, 1'b1);
        chk("oor_b_err", bus_b.cfg_err, 1'b1);
        tick();
        @(negedge clk);
        chk("oor_b_selv", bus_b.sel_valid, 1'b1);
        chk("oor_b_out", bus_b.out, 1'b1);
        chk("oor_a_out", bus_a.out, 1'b0);
        tick();
        in_v = 16'h8000;
        @(negedge clk);
        chk("oor_a_out15", bus_a.out, 1'b1);
        chk("oor_b_out15", bus_b.out, 1'b0);

        // Reset after 4 shifted bits
        tick();
        in_v = 16'hFFFF;
        w = mk(8'h24);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            head  = w[CL-1-k];
            tick();
        end
        valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_busy", bus_a.cfg_busy, 1'b0);
        chk("mid_selv", bus_a.sel_valid, 1'b0);
        chk("mid_out", bus_a.out, 1'b0);
        tick();
        rst_n = 1'b1;
        in_v = 16'h0040;
        tick();
        load(mk(8'h24), -1, 0, 1'b0, -1);
        @(negedge clk);
        chk("mid_reload_ok", bus_a.cfg_ok, 1'b1);
        tick();
        @(negedge clk);
        chk("mid_reload_out", bus_a.out, 1'b1);

`ifdef MUX_CFG_PARITY_EN
        tick();
        load({7'b0, 8'h24, 1'b1}, -1, 0, 1'b0, -1);
        @(negedge clk);
        chk("par_bad_err", bus_a.cfg_err, 1'b1);
        tick();
        load({7'b0, 8'h24, 1'b0}, -1, 0, 1'b0, -1);
        @(negedge clk);
        chk("par_good_ok", bus_a.cfg_ok, 1'b1);
`endif

        // Randomised loads, stalls, spurious starts, resets and inputs
        tick();
        rand_in = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                g  = $urandom_range(0, 3);
                i  = $urandom_range(0, 3);
                w8 = 8'((1 << (L1 + g)) | (1 << i));
                w  = mk(w8);
            end else begin
                w = 16'($urandom & ((1 << CL) - 1));
            end
            load(w, -1, 0, 1'b1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, CL - 1)) : -1);
            repeat ($urandom_range(1, 3)) tick();
        end
        rand_in = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
